// File: rtl/gf2_31_pkg.sv
// Shared field definitions for the GF(2^31) step generator, h(x) = x^31 + x^13 + x^8 + x^3 + 1.
package gf2_31_pkg;

  localparam int GF_M   = 31;
  localparam int GF_EXT = 4;

  // h(x) with the leading x^31 term removed
  localparam logic [GF_M-1:0] H_LOW = 31'h0000_2109;

  typedef enum logic {
    PAUSE = 1'b0,
    RUN   = 1'b1
  } fsm_t;

endpackage

// File: rtl/gf2_poly_mod_35.sv
// Combinational reduction of a 35-bit polynomial modulo h(x) down to 31 bits.
module gf2_poly_mod_35
  import gf2_31_pkg::*;
(
  input  logic [GF_M+GF_EXT-1:0] poly,
  output logic [GF_M-1:0]        rem
);

  // Each overflow bit x^(31+k) folds to x^k * H_LOW; H_LOW has degree 13, so one pass suffices.
  logic [GF_M-1:0] term [GF_EXT+1];

  assign term[0] = poly[GF_M-1:0];

  for (genvar gi = 0; gi < GF_EXT; gi++) begin : g_fold
    assign term[gi+1] = term[gi] ^ (poly[GF_M+gi] ? (H_LOW << gi) : '0);
  end

  assign rem = term[GF_EXT];

endmodule

// File: rtl/gf2_31_step_gen.sv
// Streaming PRNG: each accepted sample advances s <= s * x^4 mod h(x); seed load and sample counter.
module gf2_31_step_gen
  import gf2_31_pkg::*;
#(
  parameter logic [GF_M-1:0] RESET_SEED = 31'd1,
  parameter int              COUNT_W    = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en_i,
  input  logic               seed_valid_i,
  input  logic [GF_M-1:0]    seed_i,
  output logic               seed_ready_o,
  output logic               seed_err_o,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [GF_M-1:0]    out_data_o,
  output logic [COUNT_W-1:0] out_count_o
);

  if (RESET_SEED == '0) begin : g_bad_seed
    $error("RESET_SEED must be nonzero: zero is a fixed point of the step map");
  end

  fsm_t               state_reg, state_next;
  logic [GF_M-1:0]    s_reg, s_next;
  logic [COUNT_W-1:0] count_reg, count_next;
  logic               seed_err_reg, seed_err_next;
  logic               valid_reg;
  logic [GF_M-1:0]    s_stepped;
  logic               handshake;

  gf2_poly_mod_35 u_mod (
    .poly ({s_reg, {GF_EXT{1'b0}}}),
    .rem  (s_stepped)
  );

  assign handshake = valid_reg && out_ready_i;

  always_comb begin
    state_next    = state_reg;
    s_next        = s_reg;
    count_next    = count_reg;
    seed_err_next = 1'b0;
    case (state_reg)
      PAUSE: begin
        if (seed_valid_i) begin
          if (seed_i != '0) begin
            s_next     = seed_i;
            count_next = '0;
          end else begin
            seed_err_next = 1'b1;
          end
        end
        state_next = en_i ? RUN : PAUSE;
      end
      RUN: begin
        // A presented sample is held until taken; en_i only matters at the handshake.
        if (handshake) begin
          s_next     = s_stepped;
          count_next = count_reg + {{(COUNT_W-1){1'b0}}, 1'b1};
          state_next = en_i ? RUN : PAUSE;
        end
      end
      default: state_next = PAUSE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= PAUSE;
      s_reg        <= RESET_SEED;
      count_reg    <= '0;
      seed_err_reg <= 1'b0;
      valid_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      s_reg        <= s_next;
      count_reg    <= count_next;
      seed_err_reg <= seed_err_next;
      valid_reg    <= (state_next == RUN);
    end
  end

  assign seed_ready_o = (state_reg == PAUSE);
  assign seed_err_o   = seed_err_reg;
  assign out_valid_o  = valid_reg;
  assign out_data_o   = s_reg;
  assign out_count_o  = count_reg;

endmodule

// File: tb/tb_gf2_31_step_gen.sv
// Self-checking bench: directed scenarios plus randomized traffic against a polynomial-arithmetic model.
module tb_gf2_31_step_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en_i = 1'b0;
  logic        seed_valid_i = 1'b0;
  logic [30:0] seed_i = '0;
  logic        seed_ready_o;
  logic        seed_err_o;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [30:0] out_data_o;
  logic [7:0]  out_count_o;

  int checks = 0;
  int errors = 0;
  int wrap_seen = 0;

  always #5 clk = ~clk;

  gf2_31_step_gen #(.RESET_SEED(31'd1), .COUNT_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .en_i         (en_i),
    .seed_valid_i (seed_valid_i),
    .seed_i       (seed_i),
    .seed_ready_o (seed_ready_o),
    .seed_err_o   (seed_err_o),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_data_o   (out_data_o),
    .out_count_o  (out_count_o)
  );

  // Multiply by x four times, reducing by the full h(x) whenever x^31 appears.
  function automatic logic [30:0] mulx4(input logic [30:0] a);
    logic [31:0] p;
    p = {1'b0, a};
    for (int i = 0; i < 4; i++) begin
      p = p << 1;
      if (p[31]) p = p ^ 32'h8000_2109;
    end
    return p[30:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: pending-sample flag, field element, count, error pulse.
  logic        m_valid;
  logic [30:0] m_s;
  logic [7:0]  m_cnt;
  logic        m_err;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_s     <= 31'd1;
      m_cnt   <= '0;
      m_err   <= 1'b0;
    end else begin
      m_err <= 1'b0;
      if (!m_valid) begin
        if (seed_valid_i) begin
          if (seed_i != 0) begin
            m_s   <= seed_i;
            m_cnt <= '0;
          end else begin
            m_err <= 1'b1;
          end
        end
        m_valid <= en_i;
      end else if (out_ready_i) begin
        m_s     <= mulx4(m_s);
        m_cnt   <= m_cnt + 8'd1;
        m_valid <= en_i;
      end
    end
  end

  // Transfer log taken at the active edge, before the DUT's registers update.
  logic [38:0] xfer_q[$];
  always @(posedge clk) begin
    if (!rst && out_valid_o && out_ready_i) begin
      xfer_q.push_back({out_count_o, out_data_o});
      if (out_count_o == 8'd255) wrap_seen++;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("valid", {31'd0, out_valid_o}, {31'd0, m_valid});
      chk("seed_ready", {31'd0, seed_ready_o}, {31'd0, !m_valid});
      chk("seed_err", {31'd0, seed_err_o}, {31'd0, m_err});
      chk("count", {24'd0, out_count_o}, {24'd0, m_cnt});
      if (m_valid) chk("data", {1'b0, out_data_o}, {1'b0, m_s});
    end
  end

  task automatic wait_pause(input string name);
    int n;
    n = 0;
    while (out_valid_o && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (out_valid_o) begin
      errors++;
      $display("FAIL %s timeout: out_valid_o still 1 after 40 cycles", name);
    end
  endtask

  logic [30:0] exp_seq [10] = '{31'h1, 31'h10, 31'h100, 31'h1000, 31'h10000, 31'h100000,
                                31'h1000000, 31'h10000000, 31'h4212, 31'h42120};

  initial begin
    logic [30:0] held_d;
    logic [7:0]  held_c;
    logic [30:0] pre_s;

    chk("model_x32", {1'b0, mulx4(31'h1000_0000)}, 32'h4212);
    chk("model_x36", {1'b0, mulx4(31'h4212)}, 32'h42120);

    #1 rst = 1'b1;
    #20;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_valid", {31'd0, out_valid_o}, 32'd0);
    chk("rst_count", {24'd0, out_count_o}, 32'd0);
    chk("rst_ready", {31'd0, seed_ready_o}, 32'd1);
    chk("rst_data", {1'b0, out_data_o}, 32'd1);

    // Free-running stream from the reset seed
    xfer_q.delete();
    en_i = 1'b1;
    out_ready_i = 1'b1;
    repeat (11) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      chk("seq_data", {1'b0, xfer_q[i][30:0]}, {1'b0, exp_seq[i]});
      chk("seq_count", {24'd0, xfer_q[i][38:31]}, i);
    end

    // Backpressure for 5 cycles
    held_d = m_s;
    held_c = m_cnt;
    out_ready_i = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", {31'd0, out_valid_o}, 32'd1);
      chk("bp_data", {1'b0, out_data_o}, {1'b0, held_d});
      chk("bp_count", {24'd0, out_count_o}, {24'd0, held_c});
    end
    out_ready_i = 1'b1;
    @(negedge clk);
    chk("bp_resume", {1'b0, out_data_o}, {1'b0, mulx4(held_d)});

    // en_i dropped during backpressure: sample held, then PAUSE
    out_ready_i = 1'b0;
    en_i = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("drop_valid_held", {31'd0, out_valid_o}, 32'd1);
    end
    out_ready_i = 1'b1;
    @(negedge clk);
    chk("drop_pause_valid", {31'd0, out_valid_o}, 32'd0);
    chk("drop_seed_ready", {31'd0, seed_ready_o}, 32'd1);

    // Zero seed while paused
    pre_s = m_s;
    held_c = m_cnt;
    seed_valid_i = 1'b1;
    seed_i = '0;
    en_i = 1'b1;
    out_ready_i = 1'b0;
    @(negedge clk);
    seed_valid_i = 1'b0;
    chk("zseed_err", {31'd0, seed_err_o}, 32'd1);
    chk("zseed_data", {1'b0, out_data_o}, {1'b0, pre_s});
    chk("zseed_count", {24'd0, out_count_o}, {24'd0, held_c});
    @(negedge clk);
    chk("zseed_err_off", {31'd0, seed_err_o}, 32'd0);

    // All-ones seed, then asynchronous reset mid-cycle in RUN
    en_i = 1'b0;
    out_ready_i = 1'b1;
    @(negedge clk);
    wait_pause("seed_pause");
    seed_valid_i = 1'b1;
    seed_i = 31'h7FFF_FFFF;
    en_i = 1'b1;
    @(negedge clk);
    seed_valid_i = 1'b0;
    chk("seed1_data", {1'b0, out_data_o}, 32'h7FFF_FFFF);
    chk("seed1_count", {24'd0, out_count_o}, 32'd0);
    @(negedge clk);
    chk("seed2_data", {1'b0, out_data_o}, {1'b0, mulx4(31'h7FFF_FFFF)});
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", {31'd0, out_valid_o}, 32'd0);
    chk("arst_data", {1'b0, out_data_o}, 32'd1);
    chk("arst_count", {24'd0, out_count_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Long continuous run so the 8-bit counter wraps
    en_i = 1'b1;
    out_ready_i = 1'b1;
    repeat (300) @(negedge clk);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      en_i = ($urandom % 10) != 0;
      out_ready_i = ($urandom % 4) != 0;
      seed_valid_i = ($urandom % 3) == 0;
      seed_i = (($urandom % 4) == 0) ? 31'd0 : 31'($urandom);
      @(negedge clk);
    end
    seed_valid_i = 1'b0;

    checks++;
    if (wrap_seen == 0) begin
      errors++;
      $display("FAIL count_wrap actual=%0d required=nonzero", wrap_seen);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
